// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: FSM encoding,
// register-zero constant and the packed control-output bundle.
package hazard_control_unit_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bundle ordering, MSB first.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic stall_active;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_DEFAULT = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_STALL   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_JUMP    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch/jump squash control for a 5-stage pipeline, with
// saturating stall and flush event counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] STALL_REM = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state, next_state;
    logic [2:0] rem, next_rem;
    ctrl_t      ctrl;
    logic       hz;
    logic       flush_event;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        next_rem    = rem;
        ctrl        = CTRL_DEFAULT;
        flush_event = 1'b0;
        hz          = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_branch_taken) begin
            // A taken branch aborts any pending stall.
            ctrl        = CTRL_BRANCH;
            flush_event = 1'b1;
            next_state  = RUN;
            next_rem    = 3'd0;
        end else if (state == STALL) begin
            ctrl = CTRL_STALL;
            if (rem == 3'd1) begin
                next_state = RUN;
                next_rem   = 3'd0;
            end else begin
                next_rem = rem - 3'd1;
            end
        end else if (hz) begin
            ctrl = CTRL_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
                next_state = STALL;
                next_rem   = STALL_REM;
            end
        end else if (id_jump) begin
            ctrl        = CTRL_JUMP;
            flush_event = 1'b1;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign stall_active = ctrl.stall_active;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.stall_active),
        .value (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_event),
        .value (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: two hazard_control_unit instances (1-cycle/4-bit counters and
// 3-cycle/16-bit counters) driven by shared stimulus, checked against hand values.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, ex_mem_read, mem_branch_taken;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_stall_active;
    logic [3:0]  a_stall_count, a_flush_count;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_stall_active;
    logic [15:0] b_stall_count, b_flush_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
        .stall_active(a_stall_active), .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
        .stall_active(b_stall_active), .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        if (observed == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0; mem_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic load_hazard_rs8();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("rst_pc_write", a_pc_write, 0);
        check("rst_if_id_write", a_if_id_write, 0);
        check("rst_id_ex_flush", b_id_ex_flush, 0);
        tick();
        check("rst_stall_count", b_stall_count, 0);
        reset = 1'b0;
        #1;
        check("idle_pc_write", a_pc_write, 1);
        check("idle_stall", a_stall_active, 0);

        // 1: single-cycle load-use stall
        do_reset();
        load_hazard_rs8();
        #1;
        check("t1_pc_write", a_pc_write, 0);
        check("t1_if_id_write", a_if_id_write, 0);
        check("t1_id_ex_flush", a_id_ex_flush, 1);
        tick();
        ex_mem_read = 1'b0;
        #1;
        check("t1_release_pc", a_pc_write, 1);
        check("t1_stall_count", a_stall_count, 1);

        // 2: three-cycle stall; hazard dropped after first cycle must not shorten it
        do_reset();
        load_hazard_rs8();
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t2_stall_%0d", i), b_stall_active, 1);
            check($sformatf("t2_pc_%0d", i), b_pc_write, 0);
            tick();
            ex_mem_read = 1'b0;
        end
        #1;
        check("t2_release_pc", b_pc_write, 1);
        check("t2_release_stall", b_stall_active, 0);
        check("t2_stall_count", b_stall_count, 3);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("t2_reg0_no_stall", b_stall_active, 0);

        // 3: rt match only counts when the instruction reads rt
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        check("t3_rt_unused", b_stall_active, 0);
        id_uses_rt = 1'b1;
        #1;
        check("t3_rt_used", b_stall_active, 1);

        // 4: branch in second cycle of a 3-cycle stall
        do_reset();
        load_hazard_rs8();
        #1;
        check("t4_stall", b_stall_active, 1);
        tick();
        mem_branch_taken = 1'b1; ex_mem_read = 1'b0;
        #1;
        check("t4_if_id_flush", b_if_id_flush, 1);
        check("t4_id_ex_flush", b_id_ex_flush, 1);
        check("t4_ex_mem_flush", b_ex_mem_flush, 1);
        check("t4_pc_write", b_pc_write, 1);
        check("t4_stall_off", b_stall_active, 0);
        tick();
        mem_branch_taken = 1'b0;
        #1;
        check("t4_after_stall", b_stall_active, 0);
        check("t4_after_pc", b_pc_write, 1);
        check("t4_flush_count", b_flush_count, 1);
        check("t4_stall_count", b_stall_count, 1);

        // 5: jump held through stall, then squash; branch+jump counts once
        do_reset();
        load_hazard_rs8();
        id_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_held_flush_%0d", i), b_if_id_flush, 0);
            check($sformatf("t5_held_stall_%0d", i), b_stall_active, 1);
            tick();
            ex_mem_read = 1'b0;
        end
        #1;
        check("t5_jump_flush", b_if_id_flush, 1);
        check("t5_jump_pc", b_pc_write, 1);
        check("t5_jump_no_idex", b_id_ex_flush, 0);
        tick();
        check("t5_flush_count1", b_flush_count, 1);
        mem_branch_taken = 1'b1;
        #1;
        check("t5_both_ex_mem", b_ex_mem_flush, 1);
        tick();
        mem_branch_taken = 1'b0; id_jump = 1'b0;
        #1;
        check("t5_flush_count2", b_flush_count, 2);

        // 6: saturation at 15 on 4-bit counter, then reset mid-stall
        do_reset();
        load_hazard_rs8();
        repeat (20) tick();
        check("t6_saturated", a_stall_count, 15);
        check("t6_b_in_stall", b_stall_active, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_pc", b_pc_write, 0);
        check("t6_rst_stall", b_stall_active, 0);
        check("t6_rst_id_ex", b_id_ex_flush, 0);
        tick();
        reset = 1'b0; ex_mem_read = 1'b0;
        #1;
        check("t6_run_stall", b_stall_active, 0);
        check("t6_run_pc", b_pc_write, 1);
        check("t6_a_count", a_stall_count, 0);
        check("t6_b_stall_count", b_stall_count, 0);
        check("t6_b_flush_count", b_flush_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
